// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared defines, state/size types and alignment helper for the load/store unit
// Optional feature macro: LSU_RANGE_CHECK_EN
`ifndef LSU_CTRL_DEFINES
`define LSU_CTRL_DEFINES
`define RST            1'b1
`define WRITE_ENABLE   1'b1
`define READ_ENABLE    1'b0
`define ZERO32         32'h0000_0000
`define DATA_WIDTH     32
`define MEM_ADDR_WIDTH 8
`define MEM_NUM        64
`define SIZE_B         2'b00
`define SIZE_H         2'b01
`define SIZE_W         2'b10
`define LSU_IDLE       2'b00
`define LSU_RD         2'b01
`define LSU_WR         2'b10
`define LSU_RESP       2'b11
`endif

package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `LSU_IDLE,
        ST_RD   = `LSU_RD,
        ST_WR   = `LSU_WR,
        ST_RESP = `LSU_RESP
    } lsu_state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            `SIZE_B: misaligned = 1'b0;
            `SIZE_H: misaligned = off[0];
            `SIZE_W: misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - lane extraction/extension for loads and byte/half merge for read-modify-write stores
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        case (size)
            `SIZE_B: load_val = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            `SIZE_H: load_val = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
    end

    // Only the addressed byte/half is replaced; the rest of the fetched word is written back as-is.
    always_comb begin
        merged = word;
        if (size == `SIZE_B) begin
            case (offset)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
                default: merged = word;
            endcase
        end else if (size == `SIZE_H) begin
            if (offset[1])
                merged[31:16] = wdata;
            else
                merged[15:0] = wdata;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM bridging byte-addressed core requests to word memory
// Optional feature macro: LSU_RANGE_CHECK_EN
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int AW  = `MEM_ADDR_WIDTH,
    parameter int BAW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [1:0]     req_size,
    input  logic           req_unsigned,
    input  logic [BAW-1:0] req_addr,
    input  logic [31:0]    req_wdata,
    output logic           resp_valid,
    output logic [31:0]    resp_rdata,
    output logic           resp_err,
    output logic           mem_rw,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic [31:0]    mem_rdata
);

    lsu_state_t     state, state_nxt;
    logic           lat_we;
    logic           lat_uns;
    logic [1:0]     lat_size;
    logic [AW+1:0]  lat_addr;
    logic [15:0]    lat_wdata;
    logic           req_bad;
    logic           range_bad;
    logic [31:0]    load_val;
    logic [31:0]    merged;

`ifdef LSU_RANGE_CHECK_EN
    localparam logic [AW:0] WORD_LIMIT = (AW+1)'(2 * `MEM_NUM);
    assign range_bad = (|req_addr[BAW-1:AW+2]) || ({1'b0, req_addr[AW+1:2]} >= WORD_LIMIT);
`else
    logic unused_upper;
    assign unused_upper = ^req_addr[BAW-1:AW+2];
    assign range_bad    = 1'b0;
`endif

    assign req_bad = misaligned(req_size, req_addr[1:0]) || range_bad;

    lsu_lane u_lane (
        .word        (mem_rdata),
        .wdata       (lat_wdata),
        .offset      (lat_addr[1:0]),
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .load_val    (load_val),
        .merged      (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad)
                        state_nxt = ST_RESP;
                    else if (req_we && req_size == `SIZE_W)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = lat_we ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset in WR must kill the write in the same cycle, so rst gates mem_rw combinationally.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        mem_rw     = (state == ST_WR && rst != `RST) ? `WRITE_ENABLE : `READ_ENABLE;
        mem_addr   = lat_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst == `RST) begin
            state      <= ST_IDLE;
            resp_rdata <= `ZERO32;
            resp_err   <= 1'b0;
            mem_wdata  <= `ZERO32;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_size   <= `SIZE_B;
            lat_addr   <= '0;
            lat_wdata  <= 16'h0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr[AW+1:0];
                        lat_wdata <= req_wdata[15:0];
                        if (req_bad) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= `ZERO32;
                        end else if (req_we && req_size == `SIZE_W) begin
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (lat_we) begin
                        mem_wdata <= merged;
                    end else begin
                        resp_rdata <= load_val;
                        resp_err   <= 1'b0;
                    end
                end
                ST_WR: begin
                    resp_rdata <= `ZERO32;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl with a 128-word memory model
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    logic        tb_we = 1'b0;
    logic [6:0]  tb_wa = 7'h0;
    logic [31:0] tb_wd = 32'h0;

    int checks = 0;
    int failures = 0;

    int          lat;
    int          nwr;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[6:0]];

    always @(posedge clk) begin
        if (mem_rw === 1'b1)
            mem[mem_addr[6:0]] <= mem_wdata;
        else if (tb_we)
            mem[tb_wa] <= tb_wd;
    end

    lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int l, output logic [31:0] r, output logic e, output int w);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready addr=%h got=%b want=1", addr, req_ready);
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l = 0; w = 0; r = 32'hx; e = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_rw === 1'b1) w++;
            if (resp_valid === 1'b1) begin
                l = c; r = resp_rdata; e = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", resp_err); end
        checks++; if (mem_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b want=0", mem_rw); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
    endtask

    task automatic test_loads;
        logic [31:0] addrs [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        preload(7'd4, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, er, nwr);
            checks++; if (lat != 2) begin failures++; $display("FAIL load%0d_latency got=%0d want=2", i, lat); end
            checks++; if (rd !== exps[i]) begin failures++; $display("FAIL load%0d_data got=%h want=%h", i, rd, exps[i]); end
            checks++; if (er !== 1'b0 || nwr != 0) begin failures++; $display("FAIL load%0d_err_wr err=%b writes=%0d want 0/0", i, er, nwr); end
        end
    endtask

    task automatic test_subword_store;
        preload(7'd4, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF55, lat, rd, er, nwr);
        checks++; if (lat != 3) begin failures++; $display("FAIL sb_latency got=%0d want=3", lat); end
        checks++; if (nwr != 1) begin failures++; $display("FAIL sb_writes got=%0d want=1", nwr); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sb_resp err=%b rdata=%h want 0/0", er, rd); end
        checks++; if (mem[4] !== 32'h11553344) begin failures++; $display("FAIL sb_mem got=%h want=11553344", mem[4]); end
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat, rd, er, nwr);
        checks++; if (lat != 3 || nwr != 1) begin failures++; $display("FAIL sh_timing lat=%0d writes=%0d want 3/1", lat, nwr); end
        checks++; if (mem[4] !== 32'hBEEF3344) begin failures++; $display("FAIL sh_mem got=%h want=beef3344", mem[4]); end
    endtask

    task automatic test_word_store;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, lat, rd, er, nwr);
        checks++; if (lat != 2 || nwr != 1) begin failures++; $display("FAIL sw_timing lat=%0d writes=%0d want 2/1", lat, nwr); end
        checks++; if (mem[8] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h want=deadbeef", mem[8]); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, nwr);
        checks++; if (lat != 2 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_back lat=%0d data=%h want 2/deadbeef", lat, rd); end
    endtask

    task automatic test_errors;
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] addrs [3] = '{32'h13, 32'h22, 32'h10};
        for (int i = 0; i < 3; i++) begin
            issue(wes[i], sizes[i], 1'b0, addrs[i], 32'h12345678, lat, rd, er, nwr);
            checks++; if (lat != 1) begin failures++; $display("FAIL err%0d_latency got=%0d want=1", i, lat); end
            checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err%0d_resp err=%b rdata=%h want 1/0", i, er, rd); end
            checks++; if (nwr != 0) begin failures++; $display("FAIL err%0d_writes got=%0d want=0", i, nwr); end
        end
        checks++;
        if (mem[4] !== 32'hBEEF3344 || mem[8] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL err_mem w4=%h w8=%h want beef3344/deadbeef", mem[4], mem[8]);
        end
    endtask

    task automatic test_reset_in_wr;
        int seen;
        preload(7'd4, 32'hCAFEF00D);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_rw !== 1'b1) begin failures++; $display("FAIL rstwr_in_wr got=%b want=1", mem_rw); end
        rst = 1'b1;
        #1;
        checks++; if (mem_rw !== 1'b0) begin failures++; $display("FAIL rstwr_rw_gated got=%b want=0", mem_rw); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstwr_ready got=%b want=1", req_ready); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rstwr_no_resp got=%0d want=0", seen); end
        checks++; if (mem[4] !== 32'hCAFEF00D) begin failures++; $display("FAIL rstwr_mem got=%h want=cafef00d", mem[4]); end
    endtask

    task automatic test_alias;
        preload(7'd0, 32'h0A0B0C0D);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, nwr);
`ifdef LSU_RANGE_CHECK_EN
        checks++; if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL range lat=%0d err=%b rdata=%h want 1/1/0", lat, er, rd); end
`else
        checks++; if (lat != 2 || er !== 1'b0 || rd !== 32'h0A0B0C0D) begin failures++; $display("FAIL alias lat=%0d err=%b rdata=%h want 2/0/0a0b0c0d", lat, er, rd); end
`endif
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, lat, rd, er, nwr);
        checks++; if (lat != 2 || rd !== 32'h000000DE) begin failures++; $display("FAIL b2b_first lat=%0d data=%h want 2/000000de", lat, rd); end
        issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, rd, er, nwr);
        checks++; if (lat != 2 || rd !== 32'hFFFFBEEF) begin failures++; $display("FAIL b2b_second lat=%0d data=%h want 2/ffffbeef", lat, rd); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL b2b_hold valid=%b rdata=%h want 0/ffffbeef", resp_valid, resp_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset;
        test_loads;
        test_subword_store;
        test_word_store;
        test_errors;
        test_reset_in_wr;
        test_alias;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
